// File: rtl/seq_scan_pkg.sv
// Shared encodings for the 1-0-2-4 scanning arbiter: detector states,
// controller states and the nibble selection helper.
package seq_scan_pkg;

  localparam int WORD_W  = 16;
  localparam int NIB_W   = 4;
  localparam int DET_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_0    = 3'd2,
    S_2    = 3'd3,
    S_4    = 3'd4
  } det_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  // Index 0 selects the most significant nibble, which is scanned first.
  function automatic logic [NIB_W-1:0] get_nibble(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx);
    logic [NIB_W-1:0] nib;
    case (idx)
      2'd0:    nib = word[15:12];
      2'd1:    nib = word[11:8];
      2'd2:    nib = word[7:4];
      2'd3:    nib = word[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seq_step.sv
// One nibble step of the 1-0-2-4 detector. A mismatch always falls back to
// S_IDLE without re-evaluating the nibble as a new start.
module seq_step
  import seq_scan_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] nibble,
  output logic [2:0] next_state,
  output logic       hit
);

  // Detector transition and match flag.
  always_comb begin
    next_state = S_IDLE;
    hit        = 1'b0;
    case (state)
      S_IDLE, S_4: begin
        if (nibble == 4'h1) next_state = S_1;
        else                next_state = S_IDLE;
      end
      S_1: begin
        if (nibble == 4'h0) next_state = S_0;
        else                next_state = S_IDLE;
      end
      S_0: begin
        if (nibble == 4'h2) next_state = S_2;
        else                next_state = S_IDLE;
      end
      S_2: begin
        if (nibble == 4'h4) begin
          next_state = S_4;
          hit        = 1'b1;
        end else begin
          next_state = S_IDLE;
          hit        = 1'b0;
        end
      end
      default: begin
        next_state = S_IDLE;
        hit        = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_scan_arb.sv
// Two-requester round-robin arbiter that scans each accepted word for the
// nibble sequence 1-0-2-4, keeping per-requester detector context across words.
module seq_scan_arb
  import seq_scan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req0_valid_i,
  input  logic [15:0]      req0_data_i,
  input  logic             req0_last_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [15:0]      req1_data_i,
  input  logic             req1_last_i,
  output logic             req1_ready_o,
  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic [CNT_W-1:0] rsp_count_o,
  input  logic             rsp_ready_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e      state_r;
  ctrl_state_e      state_s;

  logic             grant_vld_s;
  logic             grant_id_s;
  logic             scan_done_s;
  logic             rsp_hs_s;

  logic             last_id_r;
  logic             id_r;
  logic             last_r;
  logic [15:0]      data_r;
  logic [1:0]       nib_cnt_r;
  logic [DET_W-1:0] work_state_r;
  logic [CNT_W-1:0] work_count_r;

  logic [DET_W-1:0] ctx_state_r [2];
  logic [CNT_W-1:0] ctx_count_r [2];

  logic [NIB_W-1:0] nib_s;
  logic [DET_W-1:0] step_next_s;
  logic             hit_s;
  logic [CNT_W-1:0] count_next_s;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [CNT_W-1:0] rsp_count_r;

  assign nib_s = get_nibble(data_r, nib_cnt_r);

  seq_step u_step (
    .state      (work_state_r),
    .nibble     (nib_s),
    .next_state (step_next_s),
    .hit        (hit_s)
  );

  // Saturating match counter for the word being scanned.
  always_comb begin
    count_next_s = work_count_r;
    if (hit_s && (work_count_r != CNT_MAX)) count_next_s = work_count_r + CNT_ONE;
    else                                    count_next_s = work_count_r;
  end

  // Controller next state, grant selection and handshake strobes.
  always_comb begin
    state_s     = state_r;
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    scan_done_s = 1'b0;
    rsp_hs_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // Contention goes to whoever was not served last.
        if (req0_valid_i && req1_valid_i) begin
          grant_vld_s = 1'b1;
          grant_id_s  = ~last_id_r;
        end else if (req0_valid_i) begin
          grant_vld_s = 1'b1;
          grant_id_s  = 1'b0;
        end else if (req1_valid_i) begin
          grant_vld_s = 1'b1;
          grant_id_s  = 1'b1;
        end else begin
          grant_vld_s = 1'b0;
          grant_id_s  = 1'b0;
        end
        if (grant_vld_s && rst_n_i) state_s = SCAN;
        else                        state_s = IDLE;
      end
      SCAN: begin
        if (nib_cnt_r == 2'd3) begin
          scan_done_s = 1'b1;
          if (last_r) state_s = RESP;
          else        state_s = IDLE;
        end else begin
          state_s = SCAN;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_hs_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Ready depends on valid within IDLE; rst_n_i keeps it low during reset.
  assign req0_ready_o = rst_n_i & grant_vld_s & ~grant_id_s;
  assign req1_ready_o = rst_n_i & grant_vld_s &  grant_id_s;

  // Controller state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Accepted word capture and per-nibble working context.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_id_r    <= 1'b1;
      id_r         <= 1'b0;
      last_r       <= 1'b0;
      data_r       <= 16'h0000;
      nib_cnt_r    <= 2'd0;
      work_state_r <= S_IDLE;
      work_count_r <= {CNT_W{1'b0}};
    end else if (grant_vld_s) begin
      last_id_r    <= grant_id_s;
      id_r         <= grant_id_s;
      last_r       <= grant_id_s ? req1_last_i : req0_last_i;
      data_r       <= grant_id_s ? req1_data_i : req0_data_i;
      nib_cnt_r    <= 2'd0;
      work_state_r <= ctx_state_r[grant_id_s];
      work_count_r <= ctx_count_r[grant_id_s];
    end else if (state_r == SCAN) begin
      nib_cnt_r    <= nib_cnt_r + 2'd1;
      work_state_r <= step_next_s;
      work_count_r <= count_next_s;
    end else begin
      nib_cnt_r    <= nib_cnt_r;
      work_state_r <= work_state_r;
      work_count_r <= work_count_r;
    end
  end

  // Saved per-requester context: written back after the fourth nibble,
  // cleared when that requester's result is consumed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) begin
        ctx_state_r[i] <= S_IDLE;
        ctx_count_r[i] <= {CNT_W{1'b0}};
      end
    end else if (scan_done_s) begin
      ctx_state_r[id_r] <= step_next_s;
      ctx_count_r[id_r] <= count_next_s;
    end else if (rsp_hs_s) begin
      ctx_state_r[id_r] <= S_IDLE;
      ctx_count_r[id_r] <= {CNT_W{1'b0}};
    end else begin
      ctx_state_r[id_r] <= ctx_state_r[id_r];
      ctx_count_r[id_r] <= ctx_count_r[id_r];
    end
  end

  // Registered response; id and count only change when a new result loads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_count_r <= {CNT_W{1'b0}};
    end else if (scan_done_s && last_r) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= id_r;
      rsp_count_r <= count_next_s;
    end else if (rsp_hs_s) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid_o = rsp_valid_r;
  assign rsp_id_o    = rsp_id_r;
  assign rsp_count_o = rsp_count_r;

endmodule

// File: doc/seq_scan_arb.md
SEQ_SCAN_ARB -- requirements
Module: seq_scan_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the per-requester match counter and of rsp_count_o.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req0_valid_i, input, 1, requester 0 word valid; held stable until accepted.
REQ-005 SHALL have port req0_data_i, input, 16, four nibbles; bits [15:12] scanned first.
REQ-006 SHALL have port req0_last_i, input, 1, marks the final word of requester 0's stream.
REQ-007 SHALL have port req0_ready_o, output, 1, word accepted on a cycle with valid and ready both high.
REQ-008 SHALL have ports req1_valid_i, req1_data_i, req1_last_i and req1_ready_o, identical to REQ-004..007 for requester 1.
REQ-009 SHALL have port rsp_valid_o, output, 1, result valid.
REQ-010 SHALL have port rsp_id_o, output, 1, requester the result belongs to.
REQ-011 SHALL have port rsp_count_o, output, CNT_W, number of 1-0-2-4 matches in the finished stream.
REQ-012 SHALL have port rsp_ready_i, input, 1, result consumed on a cycle with valid and ready both high.

Function
REQ-013 Controller FSM states SHALL be IDLE, SCAN and RESP.
- IDLE: grant one valid requester and assert only that requester's ready; accepting a word moves to SCAN.
- SCAN: exactly 4 cycles, one nibble per cycle, MSB nibble first.
- After SCAN: move to RESP if the word had last=1, otherwise return to IDLE.
- RESP: hold rsp_* until rsp_ready_i, then return to IDLE.
REQ-014 Arbitration SHALL be round-robin.
- Both valid in IDLE: grant the requester not served most recently.
- After reset: requester 0 has priority.
- A single valid requester: granted immediately.
REQ-015 Ready SHALL be low in SCAN and RESP; no words are accepted while a result is pending.
REQ-016 Each requester SHALL own a saved context: detector state (3 bits) and match count (CNT_W).
- Context is loaded at acceptance and written back after the 4th nibble.
- Streams interleaved at word granularity remain independent.
REQ-017 Detector states SHALL be S_IDLE, S_1, S_0, S_2 and S_4, with these transitions on each nibble n:
- S_IDLE or S_4: n==1 goes to S_1, else S_IDLE.
- S_1: n==0 goes to S_0, else S_IDLE.
- S_0: n==2 goes to S_2, else S_IDLE.
- S_2: n==4 goes to S_4, else S_IDLE.
REQ-018 A mismatching nibble SHALL NOT be re-evaluated as a new start; for example 1,1,0,2,4 yields no match.
REQ-019 Each entry to S_4 SHALL increment the count by 1, saturating at 2^CNT_W-1.
REQ-020 Sequences SHALL be detected across word boundaries of the same requester.
REQ-021 Word latency: for a word accepted at cycle T (last=1), rsp_valid_o SHALL rise at T+5; the next accept is no earlier than T+5 (no last) or the cycle after the response handshake.
REQ-022 On the response handshake, the requester's context SHALL be cleared to S_IDLE with count 0.
REQ-023 rsp_id_o and rsp_count_o SHALL be stable while rsp_valid_o is high.

Reset
REQ-024 Reset SHALL force the following:
- controller to IDLE and round-robin priority to requester 0;
- both contexts to S_IDLE with count 0;
- rsp_valid_o=0, rsp_id_o=0, rsp_count_o=0, and both ready outputs 0.
REQ-025 Reset mid-SCAN or mid-RESP SHALL discard the in-flight word or result without any response.

Structure
REQ-026 The detector state encodings and the controller state encodings SHALL live in a shared package seq_scan_pkg.
REQ-027 The detector next-state and match logic SHALL be a combinational sub-module seq_step taking (state, nibble) and returning (next_state, hit).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Single word: req0 16'h1024 with last=1 accepted at T -> rsp_valid_o at T+5, rsp_id_o=0, rsp_count_o=1.
- Cross-word match: req0 16'h0001 (last=0), then 16'h0240 (last=1) -> one response, id 0, count 1.
- No restart on mismatch: req1 16'h1102 (last=0), then 16'h4000 (last=1) -> id 1, count 0.
- Interleaved streams: req0 16'h0010 (last=0), then req1 16'h1024 (last=1), then req0 16'h2400 (last=1) -> responses id1/count1, then id0/count1.
- Arbitration and backpressure:
  - both valid on the first cycle after reset -> req0 granted first, req1 next;
  - rsp_ready_i held low for 10 cycles -> response held stable and both ready outputs stay 0.
- Saturation and reset:
  - 300 words of 16'h1024 (last=0) then 16'h0000 (last=1) -> count 255;
  - rst_n_i asserted during SCAN -> no response, and the following 16'h1024 (last=1) returns count 1.
